// File: rtl/regfile_mp_sb.sv
// Multi-port register file with registered, write-bypassed reads and a hardwired zero entry.
// Optional busy scoreboard is enabled by defining REGFILE_SCOREBOARD_EN.
module regfile_mp_sb #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]  wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr
);

  logic [WIDTH-1:0]             regs [DEPTH];
  logic [NUM_RD-1:0][WIDTH-1:0] rdNext;

  // Storage update; later write ports override earlier ones on the same entry.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != {AW{1'b0}})) begin
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Read-port next value: stored entry, overridden by same-edge writes, forced zero for entry 0.
  always_comb begin
    rdNext = {(NUM_RD*WIDTH){1'b0}};
    for (int p = 0; p < NUM_RD; p++) begin
      rdNext[p] = regs[rd_addr[p*AW +: AW]];
      for (int w = 0; w < NUM_WR; w++) begin
        rdNext[p] = (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW]))
                    ? wr_data[w*WIDTH +: WIDTH] : rdNext[p];
      end
      rdNext[p] = (rd_addr[p*AW +: AW] == {AW{1'b0}}) ? {WIDTH{1'b0}} : rdNext[p];
    end
  end

  // Registered read data.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= {(NUM_RD*WIDTH){1'b0}};
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        rd_data[p*WIDTH +: WIDTH] <= rdNext[p];
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0]  busyR;
  logic [DEPTH-1:0]  busyNext;
  logic [NUM_RD-1:0] busyRdNext;

  // Busy next state: writes retire a producer, a reservation on the same edge wins.
  always_comb begin
    busyNext   = busyR;
    busyRdNext = {NUM_RD{1'b0}};
    for (int i = 1; i < DEPTH; i++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        busyNext[i] = (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(i))) ? 1'b0 : busyNext[i];
      end
      busyNext[i] = (rsv_en && (rsv_addr == AW'(i))) ? 1'b1 : busyNext[i];
    end
    busyNext[0] = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      busyRdNext[p] = busyNext[rd_addr[p*AW +: AW]];
    end
  end

  // Busy bits and the per-port busy flags registered alongside read data.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      busyR   <= {DEPTH{1'b0}};
      rd_busy <= {NUM_RD{1'b0}};
    end else begin
      busyR   <= busyNext;
      rd_busy <= busyRdNext;
    end
  end
`else
  logic unusedRsv;
  assign unusedRsv = ^{rsv_en, rsv_addr};
  assign rd_busy   = {NUM_RD{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (two write ports, two read ports).
module tb_regfile_mp_sb;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

  logic                    clk;
  logic                    rst;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_busy;
  logic [NUM_WR-1:0]       wr_en;
  logic [NUM_WR*AW-1:0]    wr_addr;
  logic [NUM_WR*WIDTH-1:0] wr_data;
  logic                    rsv_en;
  logic [AW-1:0]           rsv_addr;

  int checks;
  int errors;

  regfile_mp_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Active edge is negedge; sample 1 time unit later.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic setRd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic setWr(input int port, input logic en, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wr_en[port]               = en;
    wr_addr[port*AW +: AW]    = a;
    wr_data[port*WIDTH +: WIDTH] = d;
  endtask

  task automatic idleWr();
    wr_en   = 2'b00;
    wr_addr = 10'd0;
    wr_data = 64'd0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    rsv_en   = 1'b0;
    rsv_addr = 5'd0;
    rd_addr  = 10'd0;
    idleWr();
    tick();
    tick();
    checkVal("reset_rd_data", {32'd0, rd_data}, 64'd0);
    checkVal("reset_rd_busy", {62'd0, rd_busy}, 64'd0);
    rst = 1'b0;

    // Preload r1..r31 through port 0
    for (int i = 1; i < 32; i++) begin
      setWr(0, 1'b1, AW'(i), 32'h100 + 32'(i));
      tick();
    end
    idleWr();
    setRd(5'd5, 5'd31);
    tick();
    checkVal("preload_r5", {32'd0, rd_data[31:0]}, 64'h105);
    checkVal("preload_r31", {32'd0, rd_data[63:32]}, 64'h11F);

    // Asynchronous reset mid-cycle clears outputs immediately
    #2;
    rst = 1'b1;
    #1;
    checkVal("async_rst_rd_data", {32'd0, rd_data}, 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      setRd(AW'(i), AW'(i));
      tick();
      checkVal($sformatf("post_rst_r%0d", i), {32'd0, rd_data}, 64'd0);
    end
    checkVal("post_rst_busy", {62'd0, rd_busy}, 64'd0);

    // Write coincident with reset is discarded
    rst = 1'b1;
    setWr(0, 1'b1, 5'd12, 32'h99);
    tick();
    rst = 1'b0;
    idleWr();
    setRd(5'd12, 5'd12);
    tick();
    checkVal("wr_during_rst", {32'd0, rd_data[31:0]}, 64'd0);

    // Write then read one edge later
    setWr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    setRd(5'd1, 5'd1);
    tick();
    idleWr();
    setRd(5'd5, 5'd5);
    tick();
    checkVal("wr_rd_r5_p0", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);
    checkVal("wr_rd_r5_p1", {32'd0, rd_data[63:32]}, 64'hDEADBEEF);

    // Same-edge bypass returns new data, not the stored value
    setWr(0, 1'b1, 5'd7, 32'h1111);
    tick();
    setWr(0, 1'b1, 5'd7, 32'h1234);
    setRd(5'd7, 5'd5);
    tick();
    checkVal("bypass_r7", {32'd0, rd_data[31:0]}, 64'h1234);
    checkVal("bypass_other_port", {32'd0, rd_data[63:32]}, 64'hDEADBEEF);
    idleWr();
    tick();
    checkVal("r7_stored", {32'd0, rd_data[31:0]}, 64'h1234);

    // Entry 0 ignores writes and always reads zero
    setWr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    setRd(5'd0, 5'd0);
    tick();
    checkVal("zero_bypass", {32'd0, rd_data}, 64'd0);
    idleWr();
    tick();
    checkVal("zero_stored", {32'd0, rd_data}, 64'd0);

    // Two write ports on one address: highest port wins
    setWr(0, 1'b1, 5'd9, 32'hAAAA);
    setWr(1, 1'b1, 5'd9, 32'h5555);
    setRd(5'd9, 5'd9);
    tick();
    checkVal("conflict_bypass", {32'd0, rd_data}, {32'h5555, 32'h5555});
    idleWr();
    tick();
    checkVal("conflict_stored", {32'd0, rd_data}, {32'h5555, 32'h5555});

    // Two write ports on distinct addresses both land
    setWr(0, 1'b1, 5'd10, 32'h0A0A);
    setWr(1, 1'b1, 5'd11, 32'h0B0B);
    tick();
    idleWr();
    setRd(5'd10, 5'd11);
    tick();
    checkVal("dual_write", {32'd0, rd_data}, {32'h0B0B, 32'h0A0A});

`ifdef REGFILE_SCOREBOARD_EN
    rsv_en   = 1'b1;
    rsv_addr = 5'd3;
    setRd(5'd3, 5'd4);
    tick();
    rsv_en = 1'b0;
    checkVal("sb_reserve", {62'd0, rd_busy}, 64'd1);
    tick();
    checkVal("sb_hold", {62'd0, rd_busy}, 64'd1);
    setWr(0, 1'b1, 5'd3, 32'h42);
    tick();
    idleWr();
    checkVal("sb_clear_busy", {62'd0, rd_busy}, 64'd0);
    checkVal("sb_clear_data", {32'd0, rd_data[31:0]}, 64'h42);
    setWr(1, 1'b1, 5'd3, 32'h77);
    rsv_en   = 1'b1;
    rsv_addr = 5'd3;
    tick();
    idleWr();
    rsv_en = 1'b0;
    checkVal("sb_set_wins", {62'd0, rd_busy}, 64'd1);
    checkVal("sb_set_wins_data", {32'd0, rd_data[31:0]}, 64'h77);
    rsv_en   = 1'b1;
    rsv_addr = 5'd0;
    setRd(5'd0, 5'd3);
    tick();
    rsv_en = 1'b0;
    checkVal("sb_r0_never_busy", {62'd0, rd_busy}, 64'd2);
    rst = 1'b1;
    #1;
    checkVal("sb_rst_immediate", {62'd0, rd_busy}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    checkVal("sb_rst_lost", {62'd0, rd_busy}, 64'd0);
`else
    rsv_en   = 1'b1;
    rsv_addr = 5'd3;
    setRd(5'd3, 5'd3);
    tick();
    rsv_en = 1'b0;
    tick();
    checkVal("no_sb_busy_zero", {62'd0, rd_busy}, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
